// File: rtl/afifo_wr_driver_bfm.sv
// rtl/afifo_wr_driver_bfm.sv - async FIFO write-side driver with command queue (optional stats: AFIFO_WR_DRV_STATS_EN)
module afifo_wr_driver_bfm #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [GAP_WIDTH-1:0]  req_gap,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wfull,
  output logic                  busy
`ifdef AFIFO_WR_DRV_STATS_EN
  ,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_mem_q [CMD_DEPTH];
  logic [GAP_WIDTH-1:0]  gap_mem_q  [CMD_DEPTH];
  logic                  push, pop;

  // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
  assign req_ready = (count_q != CNT_W'(CMD_DEPTH));
  assign push      = req_valid && req_ready;
  // The write strobe is gated directly by wfull so nothing is ever dropped by the FIFO.
  assign winc      = (state_q == ST_DRIVE) && !wfull;
  assign pop       = winc;
  assign wdata     = (state_q == ST_DRIVE) ? data_mem_q[rd_ptr_q] : '0;
  assign busy      = (state_q != ST_IDLE);

  // Occupancy after this cycle's push/pop; the FSM looks ahead with it.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Command storage; contents are only observed through the head pointer once valid.
  always_ff @(posedge wclk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= req_data;
      gap_mem_q[wr_ptr_q]  <= req_gap;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FSM next state: drive the head entry, then burn its idle gap before the next one.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!wfull) begin
          if (gap_mem_q[rd_ptr_q] != '0) begin
            gap_cnt_d = gap_mem_q[rd_ptr_q] - GAP_WIDTH'(1);
            state_d   = ST_GAP;
          end else if (count_d == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = (count_d != '0) ? ST_DRIVE : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and gap counter registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef AFIFO_WR_DRV_STATS_EN
  logic [31:0] wr_cnt_q, stall_cnt_q;

  // Saturating write and back-pressure counters.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (winc && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if ((state_q == ST_DRIVE) && wfull && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign wr_cnt    = wr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_afifo_wr_driver_bfm.sv
// tb/tb_afifo_wr_driver_bfm.sv - bench for afifo_wr_driver_bfm
module tb_afifo_wr_driver_bfm;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  g;
  } cmd_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  g;
    logic        full;
    logic        e_winc;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic        e_busy;
  } vec_t;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        req_valid, req_ready, winc, wfull, busy;
  logic [31:0] req_data, wdata;
  logic [3:0]  req_gap;
`ifdef AFIFO_WR_DRV_STATS_EN
  logic [31:0] wr_cnt, stall_cnt;
`endif

  afifo_wr_driver_bfm #(.DATA_WIDTH(32), .CMD_DEPTH(DEPTH), .GAP_WIDTH(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_gap   (req_gap),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .busy      (busy)
`ifdef AFIFO_WR_DRV_STATS_EN
    ,
    .wr_cnt    (wr_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  cmd_t        mq[$];
  cmd_t        offer[$];
  logic [31:0] dut_wr[$];
  int          m_hold;
  logic [31:0] m_wr, m_stall;
  logic        last_acc;
  vec_t        tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hold  = 0;
    m_wr    = '0;
    m_stall = '0;
  endtask

  // One clock: compare against the queue model at the falling edge, advance it at the rising edge.
  task automatic cycle();
    logic drive, e_winc, e_ready, acc;
    cmd_t c;
    @(negedge wclk);
    drive   = (mq.size() > 0) && (m_hold == 0);
    e_winc  = drive && !wfull;
    e_ready = (mq.size() < DEPTH);
    chk("winc", winc, e_winc);
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, (mq.size() > 0) || (m_hold > 0));
    if (e_winc) chk("wdata", wdata, mq[0].d);
`ifdef AFIFO_WR_DRV_STATS_EN
    chk("wr_cnt", wr_cnt, m_wr);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (winc === 1'b1) dut_wr.push_back(wdata);
    acc = req_valid && e_ready;
    @(posedge wclk);
    if (e_winc) begin
      c = mq.pop_front();
      m_hold = int'(c.g);
      if (m_wr != 32'hFFFF_FFFF) m_wr++;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (drive && wfull && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if (acc) begin
      c.d = req_data;
      c.g = req_gap;
      mq.push_back(c);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic offer_cycle();
    req_valid = (offer.size() > 0);
    if (offer.size() > 0) begin
      req_data = offer[0].d;
      req_gap  = offer[0].g;
    end
    cycle();
    if (last_acc) void'(offer.pop_front());
  endtask

  task automatic load_offer(input logic [31:0] base, input int n);
    cmd_t c;
    offer.delete();
    for (int i = 0; i < n; i++) begin
      c.d = base + 32'(i);
      c.g = 4'd0;
      offer.push_back(c);
    end
  endtask

  initial begin
    tv[0]  = '{1'b1, 32'hA0, 4'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
    tv[1]  = '{1'b1, 32'hA1, 4'd0, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b1};
    tv[2]  = '{1'b1, 32'hA2, 4'd0, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b1};
    tv[3]  = '{1'b1, 32'hA3, 4'd0, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
    tv[6]  = '{1'b1, 32'h11, 4'd3, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
    tv[7]  = '{1'b1, 32'h22, 4'd0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
    tv[9]  = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
    tv[10] = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
    tv[11] = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'h22, 1'b1, 1'b1};
    tv[12] = '{1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};

    // Reset held with a request pending.
    wrst_n    = 1'b0;
    req_valid = 1'b1;
    req_data  = 32'hDEAD;
    req_gap   = 4'd0;
    wfull     = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    chk("rst_winc", winc, 1'b0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
`ifdef AFIFO_WR_DRV_STATS_EN
    chk("rst_wr_cnt", wr_cnt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    model_reset();
    wrst_n = 1'b1;

    // Back-to-back burst and gap spacing vectors.
    for (int i = 0; i < 13; i++) begin
      req_valid = tv[i].v;
      req_data  = tv[i].d;
      req_gap   = tv[i].g;
      wfull     = tv[i].full;
      #3;
      chk($sformatf("tv%0d_winc", i), winc, tv[i].e_winc);
      chk($sformatf("tv%0d_ready", i), req_ready, tv[i].e_ready);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      if (tv[i].e_winc) chk($sformatf("tv%0d_wdata", i), wdata, tv[i].e_wdata);
      cycle();
    end

    // Back-pressure: six commands offered against a full FIFO.
    dut_wr.delete();
    load_offer(32'hB0, 6);
    wfull = 1'b1;
    repeat (6) offer_cycle();
    chk("full_ready", req_ready, 1'b0);
    chk("full_no_write", dut_wr.size(), 0);
`ifdef AFIFO_WR_DRV_STATS_EN
    chk("full_stall_cnt", stall_cnt, 32'd5);
`endif
    wfull = 1'b0;
    repeat (10) offer_cycle();
    chk("full_write_count", dut_wr.size(), 6);
    for (int i = 0; i < 6 && i < dut_wr.size(); i++)
      chk($sformatf("full_order%0d", i), dut_wr[i], 32'hB0 + 32'(i));

    // Reset while the queue is full and a write is in flight.
    load_offer(32'hD0, 4);
    wfull = 1'b1;
    repeat (4) offer_cycle();
    req_valid = 1'b0;
    wfull     = 1'b0;
    #3;
    chk("midrst_pre_winc", winc, 1'b1);
    #1;
    wrst_n = 1'b0;
    #1;
    chk("midrst_winc", winc, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", req_ready, 1'b1);
    @(posedge wclk);
    #1;
    model_reset();
    wrst_n = 1'b1;
    dut_wr.delete();
    repeat (5) cycle();
    chk("midrst_no_stale", dut_wr.size(), 0);

    // Simultaneous push and pop at occupancy one.
    load_offer(32'hC0, 10);
    repeat (12) offer_cycle();
    chk("pp_write_count", dut_wr.size(), 10);
    for (int i = 0; i < 10 && i < dut_wr.size(); i++)
      chk($sformatf("pp_order%0d", i), dut_wr[i], 32'hC0 + 32'(i));
`ifdef AFIFO_WR_DRV_STATS_EN
    chk("pp_wr_cnt", wr_cnt, 32'd10);
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_data  = $urandom;
      req_gap   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      wfull     = ($urandom_range(0, 9) < 3);
      cycle();
    end
    req_valid = 1'b0;
    wfull     = 1'b0;
    repeat (40) cycle();
    chk("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/afifo_wr_driver_bfm.md
# afifo_wr_driver_bfm

Synthesizable write-side driver for the asynchronous FIFO write port, in the write clock domain. Accepts write commands (data plus post-write idle gap) over a valid/ready request port, buffers them in a small command queue, and drives `winc`/`wdata` onto the FIFO while honouring `wfull`. It pairs with the read-side monitor BFM, which observes the opposite port, so an HVL driver proxy can push stimulus without cycle-level coupling.

## Interface
- `DATA_WIDTH`, 32, width of `wdata`/`req_data`
- `CMD_DEPTH`, 4, command queue entries; power of two, ≥2
- `GAP_WIDTH`, 4, width of per-command idle-gap field
- `wclk` in 1 — write clock; the only clock
- `wrst_n` in 1 — asynchronous, active-low reset
- `req_valid` in 1 — command present
- `req_ready` out 1 — queue can accept a command this cycle
- `req_data` in DATA_WIDTH — data to write
- `req_gap` in GAP_WIDTH — idle cycles to insert after this write
- `winc` out 1 — FIFO write strobe
- `wdata` out DATA_WIDTH — FIFO write data
- `wfull` in 1 — FIFO full flag, synchronous to `wclk`
- `busy` out 1 — queue non-empty or gap in progress
- `wr_cnt` out 32 — completed writes (macro only)
- `stall_cnt` out 32 — cycles blocked by `wfull` (macro only)

## Operation
- Queue: circular buffer, CMD_DEPTH entries of {data, gap}; count register 0..CMD_DEPTH.
- Push when `req_valid && req_ready`; `req_ready = (count != CMD_DEPTH)`, from registered count only — no push into a full queue even if a pop occurs in the same cycle.
- Pop when `winc` = 1. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: queue empty, `winc`=0. Goes to DRIVE when count becomes non-zero.
  - DRIVE: `winc = !wfull` (combinational); `wdata` = head data (always head, even when `winc`=0).
    - `wfull`=1: hold in DRIVE, no pop.
    - `wfull`=0 and head gap = 0: pop; stay DRIVE if entries remain after the pop (including a same-cycle push), else IDLE.
    - `wfull`=0 and head gap > 0: pop; load `gap_cnt` = gap−1; go to GAP.
  - GAP: `winc`=0; decrement `gap_cnt`; when it is 0, go to DRIVE if count > 0, else IDLE.
- `busy` = (state != IDLE).
- Drop on overflow is impossible: `winc` is never asserted while `wfull`=1.

## Timing
- Reset (asynchronous, immediate): state IDLE, count 0, pointers 0, `gap_cnt` 0, `winc` 0, `wdata` 0, `req_ready` 1, `busy` 0, counters 0.
- Latency: command pushed at edge N is eligible at cycle N+1; earliest `winc` is in cycle N+1.
- Back-to-back writes with gap 0 and `wfull`=0: one write per cycle.
- Write at cycle T with gap G>0: `winc`=0 for cycles T+1..T+G; next write no earlier than T+G+1.
- `wfull` rising mid-stream: `winc` drops in the same cycle; data is held; resumes the first cycle `wfull`=0.
- Pointers wrap modulo CMD_DEPTH; count never exceeds CMD_DEPTH.
- Reset mid-operation discards all queued commands and any pending gap; no `winc` is issued after `wrst_n` falls.

## Configuration
- `AFIFO_WR_DRV_STATS_EN` defined: `wr_cnt` increments on every cycle with `winc`=1. `stall_cnt` increments on every cycle in DRIVE with `wfull`=1. Both saturate at 32'hFFFF_FFFF.
- Not defined: `wr_cnt` and `stall_cnt` ports are absent; no counter logic is present.

## Test plan
- Reset with `req_valid`=1: all outputs at reset values; release → first `winc` one cycle after the first accepted push.
- Push 0xA0..0xA3 with gap 0, `wfull`=0: `winc` high for 4 consecutive cycles, `wdata` A0,A1,A2,A3; `busy` falls the cycle after the last write.
- Push 0x11 gap 3, then 0x22 gap 0: `winc` at T and T+4, idle cycles T+1..T+3.
- Hold `wfull`=1 for 5 cycles with 6 commands offered: `req_ready`=0 after 4 accepted; `winc`=0; `stall_cnt`=5 (macro on); on release, all 4 written in order, then the remaining 2.
- Fill queue, then assert `wrst_n`=0 mid-stream: `winc` drops immediately; after release, count=0 and no stale data is written.
- Push and pop in the same cycle at count=1 for 10 cycles: continuous `winc`; `wr_cnt`=10 (macro on).
